// File: rtl/spi_rx_pkg.sv
`default_nettype none
// =====================================================================
// Package  : spi_rx_pkg
// Brief    : Shared state type and defaults for the SPI word receiver.
// Revision : 1.0 - initial release
// =====================================================================
package spi_rx_pkg;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } spi_rx_state_t;

    localparam int SPI_RX_DEFAULT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/word_fifo.sv
`default_nettype none
// =====================================================================
// Module   : word_fifo
// Brief    : First-word-fall-through FIFO; a full FIFO accepts a push
//            when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// =====================================================================
module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    output logic                     o_push_accept,
    input  logic                     i_pop_req,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;

    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop_req & ~w_empty;
    assign w_push  = i_push & ((r_count < c_cnt_full) | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    assign o_push_accept = w_push;
    assign o_valid       = ~w_empty;
    assign o_head        = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count       = r_count;

endmodule
`default_nettype wire

// File: rtl/spi_word_rx_fifo.sv
`default_nettype none
// =====================================================================
// Module   : spi_word_rx_fifo
// Brief    : Mode-0 SPI slave receiver assembling WIDTH-bit words into
//            a FWFT FIFO, with sticky overflow and truncated-frame flags.
// Revision : 1.0 - initial release
// =====================================================================
module spi_word_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int WIDTH       = SPI_RX_DEFAULT_WIDTH,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclk,
    input  logic                     cs,
    input  logic                     sdi,
    output logic [WIDTH-1:0]         word_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic                     frame_err_o,
    input  logic                     clear_i
);

    localparam int c_bit_cnt_w = $clog2(WIDTH);
    localparam logic [c_bit_cnt_w-1:0] c_cnt_last = c_bit_cnt_w'(WIDTH - 1);
    localparam logic [c_bit_cnt_w-1:0] c_cnt_one  = c_bit_cnt_w'(1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;
    logic                   r_armed;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_sdi_s;
    logic w_bit_event;
    logic w_cs_fall;
    logic w_cs_rise;

    spi_rx_state_t          r_state;
    spi_rx_state_t          w_state_next;
    logic [c_bit_cnt_w-1:0] r_bit_cnt;
    logic [c_bit_cnt_w-1:0] w_bit_cnt_next;
    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       w_shift_d;
    logic [WIDTH-1:0]       w_shift_next;
    logic                   w_word_done;
    logic                   w_frame_err_set;
    logic                   r_push;
    logic                   w_push_accept;
    logic                   r_overflow;
    logic                   r_frame_err;

    // r_fill tracks when the synchronisers hold real samples, so that a cs
    // already low at reset release is not mistaken for a new frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_sdi_sync  <= '0;
            r_fill      <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
            if (r_fill[SYNC_STAGES-1] && w_cs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
    assign w_bit_event = w_sclk_s & ~r_sclk_prev & ~w_cs_s;
    assign w_cs_fall   = ~w_cs_s & r_cs_prev & r_armed;
    assign w_cs_rise   = w_cs_s & ~r_cs_prev;

    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_shift_next = {r_shift[WIDTH-2:0], w_sdi_s};
    end else begin : g_lsb_first
        assign w_shift_next = {w_sdi_s, r_shift[WIDTH-1:1]};
    end

    // A bit arriving with the cs rise is shifted before the frame end is judged.
    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_d       = r_shift;
        w_word_done     = 1'b0;
        w_frame_err_set = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next   = RX_SHIFT;
                    w_bit_cnt_next = '0;
                end
            end
            RX_SHIFT: begin
                if (w_bit_event) begin
                    w_shift_d = w_shift_next;
                    if (r_bit_cnt == c_cnt_last) begin
                        w_bit_cnt_next = '0;
                        w_word_done    = 1'b1;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_cnt_one;
                    end
                end
                if (w_cs_rise) begin
                    w_state_next = RX_IDLE;
                    if (w_bit_cnt_next != '0) begin
                        w_frame_err_set = 1'b1;
                        w_shift_d       = '0;
                    end
                    w_bit_cnt_next = '0;
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RX_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_d;
            r_push      <= w_word_done;
            r_overflow  <= (r_overflow & ~clear_i) | (r_push & ~w_push_accept);
            r_frame_err <= (r_frame_err & ~clear_i) | w_frame_err_set;
        end
    end

    // The completed word stays in r_shift while r_push is high.
    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (r_push),
        .i_push_data   (r_shift),
        .o_push_accept (w_push_accept),
        .i_pop_req     (ready_i),
        .o_head        (word_o),
        .o_valid       (valid_o),
        .o_count       (count_o)
    );

    assign busy_o      = ~w_cs_s;
    assign overflow_o  = r_overflow;
    assign frame_err_o = r_frame_err;

endmodule
`default_nettype wire

// File: doc/spi_word_rx_fifo.md
Name: spi_word_rx_fifo

Overview:
Parametrised SPI-slave receiver (mode 0) for the tuner datapath, replacing the fixed 16-bit single-word SPI front end ahead of the converter/LCD controller.
- Synchronises external sclk/cs/sdi into the system clock domain and assembles WIDTH-bit words.
- Supports multiple words per chip-select frame.
- Buffers words in a DEPTH-entry first-word-fall-through FIFO with valid/ready handshake.
- Flags overflow and truncated frames.

Parameters:
WIDTH, 16, bits per received word (>=2)
DEPTH, 4, FIFO entries (power of 2, >=2)
SYNC_STAGES, 2, synchroniser flops on sclk/cs/sdi (>=2)
MSB_FIRST, 1, 1 = first bit received lands in word MSB; 0 = first bit lands in LSB

Ports:
clk  in  1  system clock (24 MHz divided HSOSC)
reset  in  1  asynchronous, active-low reset
sclk  in  1  SPI clock from MCU, asynchronous
cs  in  1  SPI chip select, active-low, asynchronous
sdi  in  1  SPI data from MCU, asynchronous
word_o  out  WIDTH  FIFO head word
valid_o  out  1  FIFO non-empty
ready_i  in  1  consumer accepts head word when valid_o & ready_i
count_o  out  $clog2(DEPTH)+1  FIFO occupancy
busy_o  out  1  synchronised cs is low (frame in progress)
overflow_o  out  1  sticky: completed word dropped because FIFO was full
frame_err_o  out  1  sticky: cs deasserted with partial word pending
clear_i  in  1  single-cycle pulse that clears both sticky flags

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, bit counter 0, shift register 0, state RX_IDLE, synchronisers cleared to sclk=0, cs=1, sdi=0.
- Synchronisation:
  - sclk, cs and sdi each pass through SYNC_STAGES flops.
  - One additional register holds the previous sclk_s and cs_s for edge detection.
  - Bit event = sclk_s & ~sclk_prev & ~cs_s.
- Input timing constraint: sclk high and low phases each >= SYNC_STAGES+2 clk periods. Behaviour for faster sclk is undefined.
- FSM states:
  - RX_IDLE: cs_s high. On cs_s falling: go to RX_SHIFT, bit_cnt<=0.
  - RX_SHIFT, bit event:
    - Shift sdi_s into the shift register: MSB_FIRST=1 shifts left with entry at bit 0; MSB_FIRST=0 shifts right with entry at bit WIDTH-1.
    - bit_cnt increments.
    - At bit_cnt==WIDTH-1, the event completes a word, raises the internal push pulse next cycle, and wraps bit_cnt to 0.
  - RX_SHIFT, cs_s rising: go to RX_IDLE. If bit_cnt!=0, set frame_err_o and discard the partial word. bit_cnt<=0.
  - Bit event and cs_s rising in the same cycle: the bit is shifted first, then the frame end is evaluated with the updated bit_cnt.
- Latency: valid_o (for an empty FIFO) rises exactly 2 clk cycles after the cycle in which the final bit event of the word is detected.
- FIFO:
  - Pop when valid_o & ready_i; word_o and valid_o update on the next cycle.
  - Push accepted when count_o<DEPTH, or when count_o==DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow_o is set, and FIFO contents are unchanged.
  - Simultaneous push and pop leaves count_o unchanged.
  - Pointers wrap modulo DEPTH.
  - word_o is 0 when the FIFO is empty.
- Sticky flags: clear_i clears both flags. If a set event and clear_i occur in the same cycle, set wins.
- ready_i while the FIFO is empty is ignored; no underflow occurs and count_o stays 0.
- Reset asserted mid-frame: immediate clear. After release, an in-progress frame is ignored until cs_s is seen high then falling again; the FSM stays in RX_IDLE until a cs_s falling edge.

Decomposition:
- Package spi_rx_pkg:
  - typedef enum logic [0:0] spi_rx_state_t {RX_IDLE, RX_SHIFT}.
  - Constant SPI_RX_DEFAULT_WIDTH = 16.
- Sub-module word_fifo: parametrised WIDTH/DEPTH FWFT FIFO with push/pop/count and full-with-pop-push rule. The receiver top instantiates one.

Test Plan:
- Reset, cs low, MSB_FIRST=1, send 16 bits 0x00BD -> word_o=0x00BD, valid_o=1 exactly 2 clk after the last bit event, count_o=1; ready_i=1 for one cycle -> valid_o=0, word_o=0.
- One cs frame with 48 bits 0x1234, 0x5678, 0x9ABC, ready_i=0 -> count_o=3; drain gives words in order; frame_err_o=0.
- DEPTH=4, ready_i=0, send 5 words 0x0001..0x0005 -> count_o=4, overflow_o=1, drained words 1..4; 5th word sent while ready_i=1 on a full FIFO is accepted with no new overflow.
- cs high after 7 bits -> frame_err_o=1, count_o unchanged; next frame 0xBEEF received correctly; clear_i pulse -> frame_err_o=0; clear_i coinciding with a new truncated frame end -> frame_err_o stays 1.
- MSB_FIRST=0, WIDTH=8, bit sequence 1,0,1,1,0,0,0,0 -> word_o=0x0D.
- Reset pulsed after 9 bits of a frame with cs held low, then released -> no word produced until cs rises and falls again; next full frame 0xA5A5 received correctly.
